audio_decim_fir: RTL and testbench
==================================

# audio_decim_fir

- Decimating low-pass FIR placed directly downstream of the FM demodulator.
- Reads demodulated samples from the demod output FIFO and applies a TAPS-tap fixed-point low-pass filter.
- Writes one filtered audio sample to the audio FIFO for every DECIM input samples.
- Uses one shared multiplier time-multiplexed over the taps: one multiply-accumulate per cycle.

## Interface

Parameters:
- DATA_WIDTH, 32: sample, coefficient and accumulator width (signed).
- TAPS, 32: filter length; coefficients come from the shared package.
- DECIM, 8: decimation factor; must satisfy 1 ≤ DECIM ≤ TAPS.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- x_din  in  DATA_WIDTH  demod FIFO data, show-ahead (valid whenever x_empty=0).
- x_empty  in  1  demod FIFO empty.
- x_rd_en  out  1  demod FIFO pop.
- y_dout  out  DATA_WIDTH  filtered audio sample.
- y_full  in  1  audio FIFO full.
- y_wr_en  out  1  audio FIFO push; y_dout is valid in the same cycle.

## Operation

- Sample history: shreg[0..TAPS-1], signed; shreg[0] is the newest sample. Each pop shifts shreg[k] ← shreg[k-1] and loads shreg[0] ← x_din.
- Output equation: y = Σ_{k=0..TAPS-1} DEQUANTIZE(h[k]·shreg[k]).
  - Product is the 32-bit int product, wrapping modulo 2^32.
  - DEQUANTIZE is the package function: arithmetic right shift by 10 (Q10 fraction).
  - The accumulator is DATA_WIDTH wide and wraps. No saturation anywhere.
- State machine:
  - FILL: when x_empty=0, assert x_rd_en, shift x_din in, and increment cnt. When cnt reaches DECIM-1 on a pop, clear cnt and acc and go to MAC. When x_empty=1, hold with no pop.
  - MAC: each cycle, acc ← acc + DEQUANTIZE(h[tap]·shreg[tap]) and tap increments. After tap TAPS-1, go to WRITE. No pops occur in MAC.
  - WRITE: when y_full=0, assert y_wr_en with y_dout=acc (combinational from the register) and go to FILL. When y_full=1, hold; acc and shreg stay frozen.
- Filter warm-up: the first outputs see zero history. No samples are suppressed during warm-up.

## Timing

- Reset (rst_n=0, asynchronous):
  - State goes to FILL; cnt, tap, acc and all of shreg are cleared to 0.
  - Outputs x_rd_en=0, y_wr_en=0, y_dout=0.
- y_dout is 0 in every cycle where y_wr_en=0.
- Reset asserted mid-operation discards any partial accumulation and history. Samples already popped are lost.
- Throughput: with the FIFO never empty and never full, one output every DECIM+TAPS+1 cycles (41 with defaults).
- Latency: y_wr_en asserts TAPS+1 cycles after the pop of the DECIM-th sample of a group.
- x_rd_en and y_wr_en are never high in the same cycle.
- x_rd_en is never asserted while x_empty=1; y_wr_en is never asserted while y_full=1.
- Stalls: an empty FIFO mid-FILL or a full FIFO in WRITE stall indefinitely without corrupting state. Resuming produces exactly the output an unstalled run would produce.

## Structure

- Shared package (functs):
  - Coefficient constant array AUDIO_LPF_COEFFS[TAPS], Q10, symmetric.
  - DEQUANTIZE and the Q10 fraction-bit constant.
  - State enum typedef {FILL, MAC, WRITE}.
- The tap counter indexes a constant coefficient ROM. No sub-module is needed beyond a one-line coefficient lookup; keep it a single module.
- The multiplier is inferred: one 32×32 multiply per cycle feeding the accumulator register.

## Test plan

- Impulse: feed 1024, then zeros → outputs equal h[7], h[15], h[23], h[31], then 0 thereafter (defaults).
- DC: constant 1024 → outputs 1 to 3 are partial sums; output 4 onward equals Σh[k] exactly.
- Negative rounding: constant −1 with all h[k] in 1..1024 → steady-state output = −TAPS (each term floors to −1).
- Backpressure: hold y_full=1 for 100 cycles in WRITE → y_wr_en stays 0 and no pops occur. After release, one push with an unchanged value, and the output sequence is identical to the unstalled golden model.
- Starvation: toggle x_empty randomly for 10 000 input samples → exactly 1250 pushes, bit-exact against a C model using the same wrap and shift rules.
- Async reset: pulse rst_n low mid-MAC → outputs read 0 immediately. After release, the impulse test reproduces its results from scratch.

Source files
------------

// File: rtl/audio_decim_fir_pkg.sv
// Shared definitions for the decimating audio low-pass FIR: Q10 coefficient ROM,
// dequantize helper and the sequencer state type.
package audio_decim_fir_pkg;

    localparam int Q10_FRAC_BITS = 10;
    localparam int LPF_TAPS      = 32;

    // Symmetric Q10 low-pass taps, all positive so every product floors consistently
    localparam int AUDIO_LPF_COEFFS [LPF_TAPS] = '{
         3,  5,  8, 12, 17, 23, 30, 38, 47, 56, 65, 73, 80, 85, 88, 90,
        90, 88, 85, 80, 73, 65, 56, 47, 38, 30, 23, 17, 12,  8,  5,  3
    };

    typedef enum logic [1:0] {
        FILL,
        MAC,
        WRITE
    } fir_state_e;

    function automatic logic signed [31:0] dequantize(input logic signed [31:0] prod);
        return prod >>> Q10_FRAC_BITS;
    endfunction

endpackage

// File: rtl/audio_decim_fir.sv
// Decimating low-pass FIR: pops DECIM samples into the history, then runs one
// multiply-accumulate per cycle over all taps and pushes the result to the audio FIFO.
module audio_decim_fir
    import audio_decim_fir_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,
    parameter int DECIM      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] x_din,
    input  logic                  x_empty,
    output logic                  x_rd_en,
    output logic [DATA_WIDTH-1:0] y_dout,
    input  logic                  y_full,
    output logic                  y_wr_en
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    fir_state_e                   state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [TAP_W-1:0]             tap_q;
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic signed [DATA_WIDTH-1:0] acc_d;
    logic signed [DATA_WIDTH-1:0] shreg_q [TAPS];
    logic signed [31:0]           coef;
    logic signed [31:0]           prod;

    // Handshakes are gated by rst_n so nothing moves while reset is held
    always_comb begin
        x_rd_en = rst_n && (state_q == FILL) && !x_empty;
        y_wr_en = rst_n && (state_q == WRITE) && !y_full;
        y_dout  = y_wr_en ? acc_q : '0;
    end

    always_comb begin
        coef  = AUDIO_LPF_COEFFS[tap_q];
        prod  = coef * $signed(32'(shreg_q[tap_q]));
        acc_d = acc_q + DATA_WIDTH'(dequantize(prod));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                shreg_q[k] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (x_rd_en) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            shreg_q[k] <= shreg_q[k-1];
                        end
                        shreg_q[0] <= x_din;
                        if (cnt_q == CNT_W'(DECIM - 1)) begin
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            tap_q   <= '0;
                            state_q <= MAC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (tap_q == TAP_W'(TAPS - 1)) begin
                        tap_q   <= '0;
                        state_q <= WRITE;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (y_wr_en) begin
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_decim_fir.sv
// Self-checking bench for audio_decim_fir: randomized FIFO traffic against a
// sample-history reference model plus directed impulse/DC/stall/reset scenarios.
module tb_audio_decim_fir;
    import audio_decim_fir_pkg::*;

    localparam int DW    = 32;
    localparam int TAPS  = 32;
    localparam int DECIM = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] x_din = '0;
    logic          x_empty = 1'b1;
    logic          x_rd_en;
    logic [DW-1:0] y_dout;
    logic          y_full = 1'b0;
    logic          y_wr_en;

    int testsRun = 0;
    int failCount = 0;
    int popCnt = 0;
    int pushCnt = 0;
    bit starve = 1'b0;
    bit randFull = 1'b0;
    bit holdFull = 1'b0;

    int srcQ[$];
    int histQ[$];
    int expQ[$];
    int gotQ[$];

    audio_decim_fir #(.DATA_WIDTH(DW), .TAPS(TAPS), .DECIM(DECIM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_din   (x_din),
        .x_empty (x_empty),
        .x_rd_en (x_rd_en),
        .y_dout  (y_dout),
        .y_full  (y_full),
        .y_wr_en (y_wr_en)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%08h), want %0d (0x%08h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Filter output over the whole popped history; samples before reset count as zero
    function automatic int modelOutput();
        int acc;
        int n;
        int s;
        int p;
        acc = 0;
        n = histQ.size();
        for (int k = 0; k < TAPS; k++) begin
            s = (n - 1 - k >= 0) ? histQ[n-1-k] : 0;
            p = AUDIO_LPF_COEFFS[k] * s;
            acc += (p >>> Q10_FRAC_BITS);
        end
        return acc;
    endfunction

    // One clock: drive inputs at negedge, observe just after, before the next posedge
    task automatic applyStimulus();
        @(negedge clk);
        x_empty = (srcQ.size() == 0) || (starve && $urandom_range(0, 3) == 0);
        x_din   = (srcQ.size() != 0) ? srcQ[0] : $urandom;
        y_full  = holdFull || (randFull && $urandom_range(0, 3) == 0);
        #1;
        if (x_rd_en && (x_empty || y_wr_en)) checkOutput("rdEnIllegal", x_rd_en, 0);
        if (y_wr_en && y_full) checkOutput("wrEnWhileFull", y_wr_en, 0);
        if (x_rd_en) begin
            histQ.push_back(int'(x_din));
            void'(srcQ.pop_front());
            popCnt++;
            if (histQ.size() % DECIM == 0) expQ.push_back(modelOutput());
        end
        if (y_wr_en) begin
            pushCnt++;
            gotQ.push_back(int'(y_dout));
            if (expQ.size() == 0) checkOutput("unexpectedPush", 1, 0);
            else checkOutput("yDout", y_dout, expQ.pop_front());
        end else begin
            checkOutput("yIdleZero", y_dout, 0);
        end
    endtask

    task automatic clearModel();
        srcQ.delete();
        histQ.delete();
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        x_empty = 1'b0;
        x_din   = 32'h1234_5678;
        y_full  = 1'b0;
        #1;
        checkOutput("resetRdEn", x_rd_en, 0);
        checkOutput("resetWrEn", y_wr_en, 0);
        checkOutput("resetDout", y_dout, 0);
        clearModel();
        repeat (2) @(negedge clk);
        x_empty = 1'b1;
        rst_n   = 1'b1;
    endtask

    task automatic runUntilPushes(input int target, input int budget);
        int c = 0;
        while (pushCnt < target && c < budget) begin
            applyStimulus();
            c++;
        end
        checkOutput("pushCount", pushCnt, target);
    endtask

    task automatic runUntilPops(input int target, input int budget);
        int c = 0;
        while (popCnt < target && c < budget) begin
            applyStimulus();
            c++;
        end
        checkOutput("popCount", popCnt, target);
    endtask

    task automatic impulseTest(input string tag);
        int base;
        int want;
        base = pushCnt;
        srcQ.push_back(1024);
        repeat (47) srcQ.push_back(0);
        runUntilPushes(base + 6, 600);
        for (int i = 0; i < 6; i++) begin
            want = (i < 4) ? AUDIO_LPF_COEFFS[7 + 8 * i] : 0;
            checkOutput(tag, (i < gotQ.size()) ? gotQ[i] : 32'hDEAD_BEEF, want);
        end
    endtask

    initial begin
        int base;
        int pops0;
        int sumH;

        sumH = 0;
        foreach (AUDIO_LPF_COEFFS[k]) sumH += AUDIO_LPF_COEFFS[k];

        doReset();
        impulseTest("impulse");

        // DC: first three outputs are partial sums, then the full coefficient sum
        doReset();
        base = pushCnt;
        repeat (64) srcQ.push_back(1024);
        runUntilPushes(base + 8, 800);
        for (int i = 3; i < 8; i++) checkOutput("dcSteady", gotQ[i], sumH);

        // Constant -1: every term floors to -1
        doReset();
        base = pushCnt;
        repeat (64) srcQ.push_back(-1);
        runUntilPushes(base + 8, 800);
        for (int i = 3; i < 8; i++) checkOutput("negFloor", gotQ[i], -TAPS);

        // Backpressure: audio FIFO full for a long time while WRITE is pending
        doReset();
        base = pushCnt;
        pops0 = popCnt;
        holdFull = 1'b1;
        for (int i = 0; i < 16; i++) srcQ.push_back($urandom);
        repeat (150) applyStimulus();
        checkOutput("stallPops", popCnt - pops0, DECIM);
        checkOutput("stallPushes", pushCnt - base, 0);
        holdFull = 1'b0;
        runUntilPushes(base + 2, 200);
        checkOutput("stallPopsAfter", popCnt - pops0, 2 * DECIM);

        // Async reset in the middle of the MAC phase
        doReset();
        base = popCnt;
        for (int i = 0; i < DECIM; i++) srcQ.push_back($urandom);
        runUntilPops(base + DECIM, 100);
        repeat (5) applyStimulus();
        @(negedge clk);
        x_empty = 1'b0;
        x_din   = 32'h0BAD_F00D;
        y_full  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midMacRstRd", x_rd_en, 0);
        checkOutput("midMacRstWr", y_wr_en, 0);
        checkOutput("midMacRstDout", y_dout, 0);
        clearModel();
        @(negedge clk);
        x_empty = 1'b1;
        rst_n   = 1'b1;
        impulseTest("impulseAfterRst");

        // Starvation and random backpressure over a long random stream
        doReset();
        base = pushCnt;
        starve = 1'b1;
        randFull = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            srcQ.push_back(($urandom_range(0, 1) == 0) ? int'($urandom) : $urandom_range(0, 4096) - 2048);
        end
        runUntilPushes(base + 1250, 75000);
        repeat (100) applyStimulus();
        checkOutput("starvePushes", pushCnt - base, 1250);
        checkOutput("starveLeftExp", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
